pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central interlock controller for the five-stage F/D/A/C/W core pipeline.
//  Tracks in-flight destination registers in a scoreboard and stalls D on RAW/WAW hazards.
//  Freezes the pipe while memory stage C is busy, and flushes F/D and D/A on taken branches.
//  Sits beside core_top's stages; drives their hold/flush/bubble inputs.
// PARAMETERS
//  CNT_W        2  width of per-register pending counter; max in-flight writes per reg = 2**CNT_W-1
//  FLUSH_CYC    2  cycles F is held in flush after a taken branch (refetch latency), >=1
//  WB_BYPASS    1  1: source pending only via the W-stage write this cycle counts as ready
// PORTS
//  clock         in   1   core clock, rising edge
//  reset         in   1   asynchronous, active-low reset
//  d_valid       in   1   D holds a valid decoded instruction
//  d_rs1,d_rs2   in   5   D source register indices
//  d_use_rs1/2   in   1   source actually read by the instruction
//  d_rd          in   5   D destination index
//  d_is_wb       in   1   D instruction writes the regfile
//  a_br_taken    in   1   taken branch resolved in A (one-cycle pulse, A advancing)
//  c_mem_busy    in   1   C stage memory access not complete
//  w_is_wb       in   1   W writes the regfile this cycle
//  w_write_sel   in   5   W destination index
//  d_fire        out  1   D->A transfer accepted this cycle
//  f_hold        out  1   F keeps PC/fd registers
//  d_hold        out  1   D keeps its instruction
//  da_bubble     out  1   load NOP into D/A register
//  fd_flush      out  1   invalidate F/D register
//  da_flush      out  1   invalidate D/A register
//  ctrl_state    out  2   FSM state (RUN=0,RAW=1,MEMW=2,FLUSH=3)
//  stall_count   out  32  saturating count of cycles with d_fire=0 and d_valid=1
// BEHAVIOUR
//  Reset (reset=0, async): state=RUN, all counters 0, flush counter 0, stall_count 0.
//   All outputs 0 except ctrl_state=0.
//  pend(r): scoreboard count for r; r=0 never pending.
//   With WB_BYPASS=1, pend is reduced by 1 when w_is_wb and w_write_sel==r.
//  haz = d_valid & ((d_use_rs1&pend(rs1)!=0) | (d_use_rs2&pend(rs2)!=0)
//        | (d_is_wb & d_rd!=0 & cnt(d_rd)==max)).
//  Priority per cycle: c_mem_busy > a_br_taken > FLUSH state > haz > issue.
//  c_mem_busy=1: f_hold=d_hold=1, d_fire=0; A/C frozen externally; a_br_taken ignored.
//   Next state=MEMW.
//  a_br_taken (mem not busy): fd_flush=da_flush=1, d_fire=0.
//   Flush counter loaded with FLUSH_CYC; next state=FLUSH.
//  FLUSH: f_hold=0, d_fire=0, da_bubble=1; counter decrements each cycle.
//   At 1 -> RUN. A new a_br_taken reloads the counter.
//  haz: d_hold=f_hold=1, da_bubble=1, d_fire=0; state=RAW. RAW->RUN on the first cycle with haz=0.
//  Otherwise d_fire=d_valid; da_bubble=~d_valid; holds 0.
//  Scoreboard: increment cnt(d_rd) on d_fire&d_is_wb&d_rd!=0.
//   Decrement cnt(w_write_sel) on w_is_wb&w_write_sel!=0.
//   Both on the same register in one cycle: net unchanged. Never wraps.
//   A decrement at 0 is an error: hold at 0 and fire assertion.
//  Flushed D instructions never reach the scoreboard (d_fire=0), so no rollback is needed.
//  Hold/flush/fire outputs are combinational from registered state and current inputs.
//   ctrl_state and stall_count are registered.
//  Latency: a RAW stall releases in the cycle W writes the register (WB_BYPASS=1), or the cycle after (0).
//  stall_count saturates at 32'hFFFF_FFFF.
// STRUCTURE
//  Shared package core_defines.v gets the `define entries for state encodings RUN/RAW/MEMW/FLUSH and REG_ZERO=5'd0.
//  One sub-module: hazard_scoreboard (32 x CNT_W counters, inc/dec ports, two read ports with bypass).
//  The FSM, flush counter and stall counter live in the top module.
// TESTING
//  1. Reset low mid-FLUSH (counter=1) -> state=RUN, stall_count=0 immediately, all scoreboard counts 0.
//  2. Issue rd=5 (d_is_wb), next instr rs1=5 -> RAW; d_fire stays 0 until w_is_wb with sel=5.
//     WB_BYPASS=1: d_fire=1 in that same cycle.
//  3. a_br_taken with d_valid=1, rd=7 -> fd_flush=da_flush=1, cnt(7) stays 0.
//     FLUSH lasts FLUSH_CYC=2 cycles, then RUN.
//  4. c_mem_busy=1 for 3 cycles, with a_br_taken=1 in cycle 2 -> no flush, state MEMW.
//     stall_count +3 with d_valid=1.
//  5. Issue rd=3 three times without writeback (CNT_W=2) -> 4th issue to rd=3 stalls.
//     Simultaneous issue+writeback of x3 keeps cnt=3.
//  6. rd=0 and rs1=0 sequence -> never pending; back-to-back d_fire=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline interlock controller.
// No logic, no latency.
// No flow control.
package pipe_hazard_ctrl_pkg;

    // Controller FSM encoding; the values are visible on o_ctrl_state.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_RAW   = 2'd1,
        ST_MEMW  = 2'd2,
        ST_FLUSH = 2'd3
    } ctrl_state_t;

    // Architectural zero register: never written, never pending.
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         NUM_REGS = 32;

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Per-register count of in-flight writes with two source read ports and a destination-full port.
// Reads are combinational; updates land on the next clock edge.
// No flow control; issue is gated upstream by the hazard logic.
module pipe_hazard_ctrl_scoreboard
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_inc_vld,
    input  logic [4:0] i_inc_sel,
    input  logic       i_dec_vld,
    input  logic [4:0] i_dec_sel,
    input  logic [4:0] i_rs1_sel,
    input  logic [4:0] i_rs2_sel,
    input  logic [4:0] i_rd_sel,
    output logic       o_rs1_pend,
    output logic       o_rs2_pend,
    output logic       o_rd_full
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt     [NUM_REGS];
    logic [CNT_W-1:0] w_cnt_nxt [NUM_REGS];
    logic [CNT_W-1:0] w_rs1_cnt;
    logic [CNT_W-1:0] w_rs2_cnt;
    logic             w_rs1_byp;
    logic             w_rs2_byp;
    logic             w_dec_err;

    // Next count per register: simultaneous inc/dec cancel, saturate at both ends.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (i != 0) begin
                if (i_inc_vld && (i_inc_sel == 5'(i)) && !(i_dec_vld && (i_dec_sel == 5'(i)))) begin
                    if (r_cnt[i] != CNT_MAX) w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
                end else if (i_dec_vld && (i_dec_sel == 5'(i)) && !(i_inc_vld && (i_inc_sel == 5'(i)))) begin
                    if (r_cnt[i] != '0) w_cnt_nxt[i] = r_cnt[i] - CNT_ONE;
                end
            end
        end
    end

    // Counter array register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Source lookups; a write retiring in W this cycle already satisfies one pending count.
    always_comb begin
        w_rs1_cnt  = r_cnt[i_rs1_sel];
        w_rs2_cnt  = r_cnt[i_rs2_sel];
        w_rs1_byp  = WB_BYPASS && i_dec_vld && (i_dec_sel == i_rs1_sel);
        w_rs2_byp  = WB_BYPASS && i_dec_vld && (i_dec_sel == i_rs2_sel);
        o_rs1_pend = (i_rs1_sel != REG_ZERO) && (w_rs1_byp ? (w_rs1_cnt > CNT_ONE) : (w_rs1_cnt != '0));
        o_rs2_pend = (i_rs2_sel != REG_ZERO) && (w_rs2_byp ? (w_rs2_cnt > CNT_ONE) : (w_rs2_cnt != '0));
        o_rd_full  = (i_rd_sel != REG_ZERO) && (r_cnt[i_rd_sel] == CNT_MAX);
        w_dec_err  = i_dec_vld && (i_dec_sel != REG_ZERO) && (r_cnt[i_dec_sel] == '0)
                     && !(i_inc_vld && (i_inc_sel == i_dec_sel));
    end

    // A writeback for a register with nothing in flight means the pipe lost track of an instruction.
    a_no_dec_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !w_dec_err);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Interlock controller: stalls D on RAW/WAW, freezes on memory busy, flushes F/D and D/A on taken branch.
// Hold/flush/fire are combinational from state and inputs; state and stall count are registered.
// Memory busy outranks branch, which outranks flush drain, which outranks hazards.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W     = 2,
    parameter int FLUSH_CYC = 2,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_d_valid,
    input  logic [4:0]  i_d_rs1,
    input  logic [4:0]  i_d_rs2,
    input  logic        i_d_use_rs1,
    input  logic        i_d_use_rs2,
    input  logic [4:0]  i_d_rd,
    input  logic        i_d_is_wb,
    input  logic        i_a_br_taken,
    input  logic        i_c_mem_busy,
    input  logic        i_w_is_wb,
    input  logic [4:0]  i_w_write_sel,
    output logic        o_d_fire,
    output logic        o_f_hold,
    output logic        o_d_hold,
    output logic        o_da_bubble,
    output logic        o_fd_flush,
    output logic        o_da_flush,
    output logic [1:0]  o_ctrl_state,
    output logic [31:0] o_stall_count
);

    localparam int FC_W = $clog2(FLUSH_CYC + 1);

    ctrl_state_t r_state;
    ctrl_state_t w_state_nxt;
    logic [FC_W-1:0] r_flush_cnt;
    logic [FC_W-1:0] w_flush_nxt;
    logic [31:0]     r_stall_cnt;
    logic            w_rs1_pend;
    logic            w_rs2_pend;
    logic            w_rd_full;
    logic            w_haz;
    logic            w_inc_vld;

    assign w_haz = i_d_valid && ((i_d_use_rs1 && w_rs1_pend) || (i_d_use_rs2 && w_rs2_pend)
                                 || (i_d_is_wb && w_rd_full));
    assign w_inc_vld = o_d_fire && i_d_is_wb && (i_d_rd != REG_ZERO);

    pipe_hazard_ctrl_scoreboard #(
        .CNT_W     (CNT_W),
        .WB_BYPASS (WB_BYPASS)
    ) u_sb (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_inc_vld  (w_inc_vld),
        .i_inc_sel  (i_d_rd),
        .i_dec_vld  (i_w_is_wb),
        .i_dec_sel  (i_w_write_sel),
        .i_rs1_sel  (i_d_rs1),
        .i_rs2_sel  (i_d_rs2),
        .i_rd_sel   (i_d_rd),
        .o_rs1_pend (w_rs1_pend),
        .o_rs2_pend (w_rs2_pend),
        .o_rd_full  (w_rd_full)
    );

    // Prioritised pipe control and next-state; outputs are forced quiet while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        w_flush_nxt = r_flush_cnt;
        o_d_fire    = 1'b0;
        o_f_hold    = 1'b0;
        o_d_hold    = 1'b0;
        o_da_bubble = 1'b0;
        o_fd_flush  = 1'b0;
        o_da_flush  = 1'b0;
        if (i_rst_n) begin
            if (i_c_mem_busy) begin
                o_f_hold    = 1'b1;
                o_d_hold    = 1'b1;
                w_state_nxt = ST_MEMW;
            end else if (i_a_br_taken) begin
                o_fd_flush  = 1'b1;
                o_da_flush  = 1'b1;
                w_flush_nxt = FC_W'(FLUSH_CYC);
                w_state_nxt = ST_FLUSH;
            end else if (r_state == ST_FLUSH) begin
                o_da_bubble = 1'b1;
                w_flush_nxt = r_flush_cnt - FC_W'(1);
                if (r_flush_cnt <= FC_W'(1)) w_state_nxt = ST_RUN;
            end else if (w_haz) begin
                o_f_hold    = 1'b1;
                o_d_hold    = 1'b1;
                o_da_bubble = 1'b1;
                w_state_nxt = ST_RAW;
            end else begin
                o_d_fire    = i_d_valid;
                o_da_bubble = !i_d_valid;
                w_state_nxt = ST_RUN;
            end
        end
    end

    // FSM state and flush drain counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_nxt;
        end
    end

    // Saturating count of cycles where D had work but could not issue.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
        end else if (i_d_valid && !o_d_fire && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_ctrl_state  = r_state;
    assign o_stall_count = r_stall_cnt;

endmodule
